// File: rtl/pwm_breath_ctrl_pkg.sv
// Shared state encoding for the breathing-PWM sequencer; HOLD_* states are only reachable with PWM_BREATH_HOLD_EN.
// Holds no logic, so it adds no latency and has no flow control of its own.
package pwm_breath_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RAMP_UP   = 3'd1;
  localparam logic [2:0] ST_HOLD_HIGH = 3'd2;
  localparam logic [2:0] ST_RAMP_DOWN = 3'd3;
  localparam logic [2:0] ST_HOLD_LOW  = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    RAMP_UP   = ST_RAMP_UP,
    HOLD_HIGH = ST_HOLD_HIGH,
    RAMP_DOWN = ST_RAMP_DOWN,
    HOLD_LOW  = ST_HOLD_LOW
  } state_e;

endpackage

// File: rtl/pwm_breath_ctrl_if.sv
// Control/config bundle between a host and the breathing sequencer; outputs feed the PWM core.
// Plain level/pulse signals with no handshake: start is dropped while busy is high.
interface pwm_breath_ctrl_if #(
  parameter int N  = 16,
  parameter int PW = 16
);
  logic          start;
  logic          stop;
  logic          one_shot;
  logic [N-1:0]  period_in;
  logic [N-1:0]  duty_min;
  logic [N-1:0]  duty_max;
  logic [N-1:0]  step;
  logic [PW-1:0] step_div;
  logic [PW-1:0] hold_ticks;
  logic [N-1:0]  period_out;
  logic [N-1:0]  duty_out;
  logic          busy;
  logic          cycle_done;
  logic          cfg_err;

  modport master (
    output start, stop, one_shot, period_in, duty_min, duty_max, step, step_div, hold_ticks,
    input  period_out, duty_out, busy, cycle_done, cfg_err
  );

  modport slave (
    input  start, stop, one_shot, period_in, duty_min, duty_max, step, step_div, hold_ticks,
    output period_out, duty_out, busy, cycle_done, cfg_err
  );
endinterface

// File: rtl/pwm_breath_ctrl_tick_gen.sv
// Prescaler: tick is high on every (div+1)-th clock; clr restarts the count at 0.
// Tick is combinational from the counter, so it is usable in the same cycle; no backpressure.
module pwm_tick_gen #(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [PW-1:0] div,
  output logic          tick
);

  logic [PW-1:0] cnt;

  assign tick = (cnt == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/pwm_breath_ctrl.sv
// Breathing-LED duty sequencer: ramps duty between captured floor/ceiling; PWM_BREATH_HOLD_EN adds hold plateaus.
// Outputs registered, start accepted -> outputs valid next clock; no backpressure, start ignored while busy.
module pwm_breath_ctrl
  import pwm_breath_pkg::*;
#(
  parameter int N  = 16,
  parameter int PW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_breath_ctrl_if.slave  bus
);

  state_e        state;
  logic [N-1:0]  period_r;
  logic [N-1:0]  duty_r;
  logic [N-1:0]  min_r;
  logic [N-1:0]  max_r;
  logic [N-1:0]  step_r;
  logic [PW-1:0] div_r;
  logic          one_shot_r;
  logic          stop_pending;
  logic          busy_r;
  logic          done_r;
  logic          err_r;

`ifdef PWM_BREATH_HOLD_EN
  logic [PW-1:0] hold_r;
  logic [PW-1:0] hold_cnt;
`else
  logic          unused_hold;
  assign unused_hold = ^bus.hold_ticks;
`endif

  logic          tick;
  logic          adv;
  logic          clr;
  logic          cyc_end;
  logic          cfg_bad;
  logic          up_done;
  logic          dn_done;
  logic          go_idle;
  logic [N:0]    up_sum;
  logic [N-1:0]  dn_gap;

  pwm_tick_gen #(.PW(PW)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .div   (div_r),
    .tick  (tick)
  );

  // Sum is one bit wider so a ceiling near 2^N cannot wrap; duty never drops below min_r, so dn_gap cannot underflow.
  always_comb begin
    up_sum  = {1'b0, duty_r} + {1'b0, step_r};
    dn_gap  = duty_r - min_r;
    up_done = (up_sum >= {1'b0, max_r});
    dn_done = (dn_gap < step_r) || (duty_r == min_r);
    cfg_bad = (bus.duty_min > bus.duty_max) || (bus.step == '0);
    go_idle = one_shot_r || stop_pending || bus.stop;
    adv     = 1'b0;
    case (state)
      RAMP_UP:   adv = tick && up_done;
      RAMP_DOWN: adv = tick && dn_done;
`ifdef PWM_BREATH_HOLD_EN
      HOLD_HIGH,
      HOLD_LOW:  adv = (hold_r == '0) || (tick && (hold_cnt == hold_r - PW'(1)));
`endif
      default:   adv = 1'b0;
    endcase
    // Every state change restarts the prescaler, so each state sees a full tick period first.
    clr = (state == IDLE) || adv;
`ifdef PWM_BREATH_HOLD_EN
    cyc_end = adv && (state == HOLD_LOW);
`else
    cyc_end = adv && (state == RAMP_DOWN);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      period_r     <= '0;
      duty_r       <= '0;
      min_r        <= '0;
      max_r        <= '0;
      step_r       <= '0;
      div_r        <= '0;
      one_shot_r   <= 1'b0;
      stop_pending <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
`ifdef PWM_BREATH_HOLD_EN
      hold_r       <= '0;
      hold_cnt     <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      if (state != IDLE && bus.stop) begin
        stop_pending <= 1'b1;
      end
`ifdef PWM_BREATH_HOLD_EN
      if (clr) begin
        hold_cnt <= '0;
      end else if (tick) begin
        hold_cnt <= hold_cnt + PW'(1);
      end
`endif
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (cfg_bad) begin
              err_r <= 1'b1;
            end else begin
              state        <= RAMP_UP;
              busy_r       <= 1'b1;
              period_r     <= bus.period_in;
              duty_r       <= bus.duty_min;
              min_r        <= bus.duty_min;
              max_r        <= bus.duty_max;
              step_r       <= bus.step;
              div_r        <= bus.step_div;
              one_shot_r   <= bus.one_shot;
              stop_pending <= 1'b0;
`ifdef PWM_BREATH_HOLD_EN
              hold_r       <= bus.hold_ticks;
`endif
            end
          end
        end
        RAMP_UP: begin
          if (tick) begin
            if (up_done) begin
              duty_r <= max_r;
`ifdef PWM_BREATH_HOLD_EN
              state  <= HOLD_HIGH;
`else
              state  <= RAMP_DOWN;
`endif
            end else begin
              duty_r <= up_sum[N-1:0];
            end
          end
        end
        RAMP_DOWN: begin
          if (tick) begin
            if (dn_done) begin
              duty_r <= min_r;
`ifdef PWM_BREATH_HOLD_EN
              state  <= HOLD_LOW;
`endif
            end else begin
              duty_r <= duty_r - step_r;
            end
          end
        end
`ifdef PWM_BREATH_HOLD_EN
        HOLD_HIGH: begin
          if (adv) begin
            state <= RAMP_DOWN;
          end
        end
        HOLD_LOW: begin
        end
`endif
        default: state <= IDLE;
      endcase
      if (cyc_end) begin
        done_r <= 1'b1;
        if (go_idle) begin
          state        <= IDLE;
          busy_r       <= 1'b0;
          duty_r       <= '0;
          period_r     <= '0;
          stop_pending <= 1'b0;
        end else begin
          state        <= RAMP_UP;
          duty_r       <= min_r;
        end
      end
    end
  end

  assign bus.period_out = period_r;
  assign bus.duty_out   = duty_r;
  assign bus.busy       = busy_r;
  assign bus.cycle_done = done_r;
  assign bus.cfg_err    = err_r;

endmodule

// File: tb/tb_pwm_breath_ctrl.sv
// Bench for pwm_breath_ctrl: per-breath duty schedules from plain arithmetic, literal waveforms, random traffic.
module tb_pwm_breath_ctrl;
  localparam int N  = 16;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_breath_ctrl_if #(.N(N), .PW(PW)) bus ();

  pwm_breath_ctrl #(.N(N), .PW(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference: the duty value expected in each remaining cycle of the current breath.
  int sched[$];
  int lit[$];
  bit m_busy, m_stop, m_one;
  int m_period, m_min, m_max, m_step, m_div, m_hold;
  int e_duty, e_period;
  bit e_busy, e_done, e_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic void build_sched();
    int d;
    int v;
    bit fin;
    int up[$];
    int dn[$];
    d = m_div + 1;
    sched.delete();
    v = m_min;
    up.push_back(v);
    fin = 0;
    while (!fin) begin
      if (v + m_step >= m_max) begin v = m_max; fin = 1; end
      else v = v + m_step;
      up.push_back(v);
    end
    v = m_max;
    dn.push_back(v);
    fin = 0;
    while (!fin) begin
      if ((v - m_min < m_step) || (v == m_min)) begin v = m_min; fin = 1; end
      else v = v - m_step;
      dn.push_back(v);
    end
    for (int i = 0; i < up.size() - 1; i++) repeat (d) sched.push_back(up[i]);
`ifdef PWM_BREATH_HOLD_EN
    repeat ((m_hold == 0) ? 1 : m_hold * d) sched.push_back(m_max);
`endif
    for (int i = 0; i < dn.size() - 1; i++) repeat (d) sched.push_back(dn[i]);
`ifdef PWM_BREATH_HOLD_EN
    repeat ((m_hold == 0) ? 1 : m_hold * d) sched.push_back(m_min);
`endif
  endfunction

  // Advance the reference across one rising edge, using the inputs that were present before it.
  task automatic model_step();
    e_done = 0;
    e_err  = 0;
    if (!m_busy) begin
      if (bus.start) begin
        if ((bus.duty_min > bus.duty_max) || (bus.step == '0)) begin
          e_err = 1;
        end else begin
          m_period = int'(bus.period_in);
          m_min    = int'(bus.duty_min);
          m_max    = int'(bus.duty_max);
          m_step   = int'(bus.step);
          m_div    = int'(bus.step_div);
          m_hold   = int'(bus.hold_ticks);
          m_one    = bus.one_shot;
          m_stop   = 0;
          build_sched();
          m_busy   = 1;
        end
      end
    end else begin
      if (bus.stop) m_stop = 1;
      void'(sched.pop_front());
      if (sched.size() == 0) begin
        e_done = 1;
        if (m_one || m_stop) m_busy = 0;
        else build_sched();
      end
    end
    e_busy   = m_busy;
    e_duty   = m_busy ? sched[0] : 0;
    e_period = m_busy ? m_period : 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    chk("duty_out",   32'(bus.duty_out),   32'(e_duty));
    chk("period_out", 32'(bus.period_out), 32'(e_period));
    chk("busy",       32'(bus.busy),       32'(e_busy));
    chk("cycle_done", 32'(bus.cycle_done), 32'(e_done));
    chk("cfg_err",    32'(bus.cfg_err),    32'(e_err));
  endtask

  task automatic set_cfg(input int per, input int mn, input int mx, input int st,
                         input int dv, input int hd, input bit os);
    bus.period_in  = N'(per);
    bus.duty_min   = N'(mn);
    bus.duty_max   = N'(mx);
    bus.step       = N'(st);
    bus.step_div   = PW'(dv);
    bus.hold_ticks = PW'(hd);
    bus.one_shot   = os;
  endtask

  task automatic lit_add(input int v, input int n);
    repeat (n) lit.push_back(v);
  endtask

  // Start with the configured inputs and require the literal duty waveform, then one-shot return to IDLE.
  task automatic run_literal(input string nm, input int per);
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    chk({nm, " model_len"}, 32'(sched.size()), 32'(lit.size()));
    for (int i = 0; i < lit.size(); i++)
      chk({nm, " model_duty"}, (i < sched.size()) ? 32'(sched[i]) : 32'hFFFF_FFFF, 32'(lit[i]));
    chk({nm, " period"}, 32'(bus.period_out), 32'(per));
    for (int i = 0; i < lit.size(); i++) begin
      chk({nm, " duty"}, 32'(bus.duty_out), 32'(lit[i]));
      chk({nm, " busy"}, 32'(bus.busy), 32'd1);
      cycle();
    end
    chk({nm, " done"},     32'(bus.cycle_done), 32'd1);
    chk({nm, " idle"},     32'(bus.busy),       32'd0);
    chk({nm, " idle_duty"}, 32'(bus.duty_out),  32'd0);
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst duty_out",   32'(bus.duty_out),   32'd0);
    chk("rst period_out", 32'(bus.period_out), 32'd0);
    chk("rst busy",       32'(bus.busy),       32'd0);
    chk("rst cycle_done", 32'(bus.cycle_done), 32'd0);
    chk("rst cfg_err",    32'(bus.cfg_err),    32'd0);
    bus.start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst start_ignored", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    m_busy = 0;
    m_stop = 0;
    sched.delete();
    e_duty = 0; e_period = 0; e_busy = 0; e_done = 0; e_err = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int k;
    int ndone;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 1'b0);
    m_busy = 0; m_stop = 0;
    #2;
    chk("init duty_out",   32'(bus.duty_out),   32'd0);
    chk("init period_out", 32'(bus.period_out), 32'd0);
    chk("init busy",       32'(bus.busy),       32'd0);
    chk("init cycle_done", 32'(bus.cycle_done), 32'd0);
    chk("init cfg_err",    32'(bus.cfg_err),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    e_duty = 0; e_period = 0; e_busy = 0; e_done = 0; e_err = 0;
    repeat (2) cycle();

    // Rejected configurations: min above max, then zero step.
    set_cfg(300, 50, 40, 10, 0, 0, 1'b1);
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    chk("minmax cfg_err", 32'(bus.cfg_err), 32'd1);
    chk("minmax busy",    32'(bus.busy),    32'd0);
    cycle();
    chk("minmax err_clears", 32'(bus.cfg_err), 32'd0);
    set_cfg(300, 0, 100, 0, 0, 0, 1'b1);
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    chk("step0 cfg_err", 32'(bus.cfg_err), 32'd1);
    chk("step0 busy",    32'(bus.busy),    32'd0);
    cycle();

`ifdef PWM_BREATH_HOLD_EN
    set_cfg(1000, 0, 100, 25, 0, 2, 1'b1);
    lit.delete();
    lit_add(0, 1); lit_add(25, 1); lit_add(50, 1); lit_add(75, 1); lit_add(100, 3);
    lit_add(75, 1); lit_add(50, 1); lit_add(25, 1); lit_add(0, 3);
    run_literal("step25_hold2", 1000);
    cycle();
    set_cfg(500, 0, 100, 30, 1, 0, 1'b1);
    lit.delete();
    lit_add(0, 2); lit_add(30, 2); lit_add(60, 2); lit_add(90, 2); lit_add(100, 3);
    lit_add(70, 2); lit_add(40, 2); lit_add(10, 2); lit_add(0, 1);
    run_literal("step30_clamp", 500);
`else
    set_cfg(1000, 0, 100, 25, 0, 2, 1'b1);
    lit.delete();
    lit_add(0, 1); lit_add(25, 1); lit_add(50, 1); lit_add(75, 1); lit_add(100, 1);
    lit_add(75, 1); lit_add(50, 1); lit_add(25, 1); lit_add(0, 1);
    run_literal("step25_nohold", 1000);
    cycle();
    set_cfg(500, 0, 100, 30, 3, 0, 1'b1);
    lit.delete();
    lit_add(0, 4); lit_add(30, 4); lit_add(60, 4); lit_add(90, 4);
    lit_add(100, 4); lit_add(70, 4); lit_add(40, 4); lit_add(10, 4);
    run_literal("div3_oneshot", 500);
`endif
    cycle();

    // Stop during the up ramp, with a start in the same cycle: breath finishes, then IDLE.
    set_cfg(200, 10, 120, 20, 1, 1, 1'b0);
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    repeat (3) cycle();
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    set_cfg(999, 0, 5, 1, 0, 0, 1'b1);
    cycle();
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    k = 0;
    ndone = 0;
    while (m_busy && k < 2000) begin
      cycle();
      if (bus.cycle_done) ndone++;
      k++;
    end
    chk("stop idle_busy",  32'(bus.busy),       32'd0);
    chk("stop done_pulse", 32'(bus.cycle_done), 32'd1);
    chk("stop duty_zero",  32'(bus.duty_out),   32'd0);
    chk("stop one_breath", 32'(ndone),          32'd1);
    cycle();

    // Reset while ramping down.
    set_cfg(1000, 0, 100, 25, 0, 2, 1'b0);
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    repeat (7) cycle();
`ifdef PWM_BREATH_HOLD_EN
    chk("pre_rst duty", 32'(bus.duty_out), 32'd75);
`else
    chk("pre_rst duty", 32'(bus.duty_out), 32'd25);
`endif
    do_reset();
    repeat (4) cycle();
    chk("post_rst no_resume", 32'(bus.busy), 32'd0);

    // Randomized traffic: config churn while busy, stray starts/stops, occasional reset.
    for (int c = 0; c < 8000; c++) begin
      if ($urandom_range(0, 2999) == 0) do_reset();
      bus.stop  = ($urandom_range(0, 199) == 0);
      bus.start = m_busy ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 3) == 0);
      set_cfg(int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 150)),
              int'($urandom_range(0, 250)),
              ($urandom_range(0, 40) == 0) ? 0 : int'($urandom_range(1, 70)),
              int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0));
      cycle();
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
